// File: rtl/lcd_ctrl_if.sv
// Byte request channel from the LSU/IO store path into the character-LCD sequencer.
// The requester holds req_rs/req_data stable with req_vld until it sees req_rdy at a clock edge.
interface lcd_ctrl_if;
    logic       req_vld;
    logic       req_rdy;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (output req_vld, output req_rs, output req_data, input req_rdy);
    modport slave  (input req_vld, input req_rs, input req_data, output req_rdy);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD sequencer: autonomous power-up/init, then one command or data byte
// per handshake with setup / enable / hold / execution-wait timing on the packed o_io_lcd word.
module lcd_ctrl #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    lcd_ctrl_if.slave   req,
    input  logic        i_lcd_on,
    output logic        o_init_done,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);

    // A zero-length phase would collapse the state machine, so every duration is at least one cycle.
    localparam int PWRUP_N = (PWRUP_CYC    < 1) ? 1 : PWRUP_CYC;
    localparam int SETUP_N = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
    localparam int EN_N    = (EN_CYC       < 1) ? 1 : EN_CYC;
    localparam int HOLD_N  = (HOLD_CYC     < 1) ? 1 : HOLD_CYC;
    localparam int CMD_N   = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
    localparam int CLR_N   = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;

    localparam int MAX_A = (PWRUP_N > SETUP_N) ? PWRUP_N : SETUP_N;
    localparam int MAX_B = (EN_N > HOLD_N) ? EN_N : HOLD_N;
    localparam int MAX_C = (CMD_N > CLR_N) ? CMD_N : CLR_N;
    localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_N = (MAX_D > MAX_C) ? MAX_D : MAX_C;
    localparam int CW    = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        SETUP,
        EN_HI,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    function automatic logic [7:0] init_rom(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] dur_m1;
    logic          last;
    logic [2:0]    idx;
    logic          rs_q;
    logic [7:0]    data_q;
    logic          en_q;
    logic          rdy_q;
    logic          busy_q;
    logic          done_q;
    logic          en_n;
    logic          rdy_n;
    logic          busy_n;
    logic          done_n;
    logic          accept;
    logic          is_clr;

    assign accept = req.req_vld && rdy_q;
    // Clear display and return home need the long execution wait.
    assign is_clr = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    always_comb begin
        dur_m1 = '0;
        case (state)
            PWRUP:   dur_m1 = CW'(PWRUP_N - 1);
            SETUP:   dur_m1 = CW'(SETUP_N - 1);
            EN_HI:   dur_m1 = CW'(EN_N - 1);
            HOLD:    dur_m1 = CW'(HOLD_N - 1);
            WAIT:    dur_m1 = is_clr ? CW'(CLR_N - 1) : CW'(CMD_N - 1);
            default: dur_m1 = '0;
        endcase
    end

    assign last = (cnt == dur_m1);

    // Outputs are computed from the next state so the registered copies line up with the state they describe.
    always_comb begin
        state_n = state;
        case (state)
            PWRUP:   if (last) state_n = LOAD;
            LOAD:    state_n = SETUP;
            SETUP:   if (last) state_n = EN_HI;
            EN_HI:   if (last) state_n = HOLD;
            HOLD:    if (last) state_n = WAIT;
            WAIT:    if (last) state_n = (idx < 3'd4) ? LOAD : IDLE;
            IDLE:    if (accept) state_n = SETUP;
            default: state_n = PWRUP;
        endcase
        en_n   = (state_n == EN_HI);
        rdy_n  = (state_n == IDLE);
        busy_n = (state_n != IDLE);
        done_n = done_q || (state_n == IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= PWRUP;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt    <= '0;
            idx    <= 3'd0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            en_q   <= 1'b0;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            if ((state_n != state) || (state == IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == LOAD) begin
                rs_q   <= 1'b0;
                data_q <= init_rom(idx[1:0]);
                idx    <= idx + 3'd1;
            end else if ((state == IDLE) && accept) begin
                rs_q   <= req.req_rs;
                data_q <= req.req_data;
            end
            en_q   <= en_n;
            rdy_q  <= rdy_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    assign req.req_rdy = rdy_q;
    assign o_init_done = done_q;
    assign o_busy      = busy_q;
    assign o_io_lcd    = {i_lcd_on, 20'b0, rs_q, 1'b0, en_q, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: timing of init and byte transfers is predicted from the
// phase-length arithmetic and compared with EN pulses and handshakes observed on the ports.
module tb_lcd_ctrl;

    localparam int P_PWRUP = 10;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_HOLD  = 1;
    localparam int P_CMD   = 5;
    localparam int P_CLR   = 20;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        lcd_on = 1'b0;
    logic        init_done;
    logic        busy;
    logic [31:0] io_lcd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    lcd_ctrl_if req ();

    lcd_ctrl #(
        .PWRUP_CYC    (P_PWRUP),
        .SETUP_CYC    (P_SETUP),
        .EN_CYC       (P_EN),
        .HOLD_CYC     (P_HOLD),
        .CMD_WAIT_CYC (P_CMD),
        .CLR_WAIT_CYC (P_CLR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .req         (req),
        .i_lcd_on    (lcd_on),
        .o_init_done (init_done),
        .o_busy      (busy),
        .o_io_lcd    (io_lcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: one record per EN pulse, start = index of the edge that raised EN.
    typedef struct {
        int          start;
        int          width;
        logic [31:0] word;
        logic        stable;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    logic   en_prev = 1'b0;
    int     acc_cyc_q[$];

    always @(negedge clk) begin
        if (io_lcd[8] && !en_prev) begin
            cur.start  = cyc;
            cur.width  = 1;
            cur.word   = io_lcd;
            cur.stable = 1'b1;
        end else if (io_lcd[8] && en_prev) begin
            cur.width = cur.width + 1;
            if (io_lcd[30:0] !== cur.word[30:0]) cur.stable = 1'b0;
        end else if (!io_lcd[8] && en_prev) begin
            pulses.push_back(cur);
        end
        en_prev = io_lcd[8];
        if (req.req_vld && req.req_rdy && !reset) acc_cyc_q.push_back(cyc + 1);
    end

    function automatic logic [7:0] rom(input int k);
        case (k)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD;
    endfunction

    function automatic int byte_period(input logic rs, input logic [7:0] d);
        return P_SETUP + P_EN + P_HOLD + wait_of(rs, d) + 1;
    endfunction

    function automatic int init_en_start(input int k);
        int t;
        t = P_PWRUP + 1 + P_SETUP;
        for (int j = 0; j < k; j++) t += P_EN + P_HOLD + wait_of(1'b0, rom(j)) + 1 + P_SETUP;
        return t;
    endfunction

    function automatic int init_total();
        int t;
        t = P_PWRUP;
        for (int j = 0; j < 4; j++) t += 1 + P_SETUP + P_EN + P_HOLD + wait_of(1'b0, rom(j));
        return t;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d, output int acc);
        req.req_rs   = rs;
        req.req_data = d;
        req.req_vld  = 1'b1;
        acc = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (req.req_rdy === 1'b1) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("[TB] FAIL send_accept: byte %h not accepted within 400 cycles", d);
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick(1);
            if (busy === 1'b0 && io_lcd[8] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL idle_timeout: busy=%b en=%b, required idle within 3000 cycles", busy, io_lcd[8]);
        end
    endtask

    task automatic check_pulse(input int i, input logic rs, input logic [7:0] d, input int start);
        logic [10:0] exp_low;
        exp_low = {rs, 1'b0, 1'b1, d};
        n_checks++;
        if (pulses[i].word[10:0] !== exp_low) begin
            n_fail++;
            $display("[TB] FAIL pulse%0d_word: got %h required %h", i, pulses[i].word[10:0], exp_low);
        end
        n_checks++;
        if (pulses[i].width !== P_EN || pulses[i].stable !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pulse%0d_width: got %0d stable=%b required %0d stable=1", i, pulses[i].width, pulses[i].stable, P_EN);
        end
        n_checks++;
        if (pulses[i].start !== start) begin
            n_fail++;
            $display("[TB] FAIL pulse%0d_start: got %0d required %0d", i, pulses[i].start, start);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        lcd_on       = 1'b0;
        req.req_vld  = 1'b0;
        req.req_rs   = 1'b0;
        req.req_data = 8'h00;
        tick(3);
        n_checks++;
        if (io_lcd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_lcd: got %h required 00000000", io_lcd);
        end
        n_checks++;
        if (req.req_rdy !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: rdy=%b done=%b busy=%b required 0 0 1", req.req_rdy, init_done, busy);
        end
        lcd_on = 1'b1;
        #1;
        n_checks++;
        if (io_lcd !== 32'h8000_0000) begin
            n_fail++;
            $display("[TB] FAIL lcd_on_bit: got %h required 80000000", io_lcd);
        end
        lcd_on = 1'b0;
        #1;
    endtask

    // A request is held through the whole init and must be taken exactly once, on the first IDLE cycle.
    task automatic test_init_stall();
        int r;
        int done_cyc;
        reset        = 1'b1;
        req.req_vld  = 1'b1;
        req.req_rs   = 1'b1;
        req.req_data = 8'h55;
        tick(2);
        pulses.delete();
        acc_cyc_q.delete();
        reset = 1'b0;
        r = cyc;
        done_cyc = -1000;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (init_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_checks++;
        if (done_cyc - r !== init_total()) begin
            n_fail++;
            $display("[TB] FAIL init_done_time: got %0d required %0d", done_cyc - r, init_total());
        end
        n_checks++;
        if (req.req_rdy !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL init_idle_flags: rdy=%b busy=%b required 1 0", req.req_rdy, busy);
        end
        n_checks++;
        if (pulses.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL init_pulse_count: got %0d required 4", pulses.size());
        end
        tick(1);
        req.req_vld = 1'b0;
        n_checks++;
        if (acc_cyc_q.size() !== 1 || acc_cyc_q[0] !== done_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL stall_accept: count=%0d required 1 at edge %0d", acc_cyc_q.size(), done_cyc + 1);
        end
        n_checks++;
        if (req.req_rdy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rdy_after_accept: got %b required 0", req.req_rdy);
        end
        wait_idle();
        n_checks++;
        if (pulses.size() !== 5 || acc_cyc_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL stall_totals: pulses=%0d accepts=%0d required 5 1", pulses.size(), acc_cyc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) check_pulse(k, 1'b0, rom(k), r + init_en_start(k));
            check_pulse(4, 1'b1, 8'h55, done_cyc + 1 + P_SETUP);
        end
    endtask

    task automatic test_back_to_back();
        logic       rs_l [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] d_l  [5] = '{8'h41, 8'h01, 8'h80, 8'h02, 8'h01};
        int         acc  [5];
        lcd_on = 1'b1;
        pulses.delete();
        for (int i = 0; i < 5; i++) begin
            send_byte(rs_l[i], d_l[i], acc[i]);
            n_checks++;
            if (req.req_rdy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL b2b_rdy%0d: got %b required 0", i, req.req_rdy);
            end
            if (i > 0) begin
                n_checks++;
                if (acc[i] - acc[i-1] !== byte_period(rs_l[i-1], d_l[i-1])) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d required %0d", i, acc[i] - acc[i-1], byte_period(rs_l[i-1], d_l[i-1]));
                end
            end
        end
        req.req_vld = 1'b0;
        wait_idle();
        n_checks++;
        if (pulses.size() !== 5) begin
            n_fail++;
            $display("[TB] FAIL b2b_pulse_count: got %0d required 5", pulses.size());
        end else begin
            n_checks++;
            if (pulses[0].word !== 32'h8000_0541) begin
                n_fail++;
                $display("[TB] FAIL data_word: got %h required 80000541", pulses[0].word);
            end
            for (int i = 0; i < 5; i++) check_pulse(i, rs_l[i], d_l[i], acc[i] + P_SETUP);
        end
    endtask

    task automatic test_random();
        logic       rs_q[$];
        logic [7:0] d_q[$];
        int         acc_q[$];
        logic       rs;
        logic [7:0] d;
        int         acc;
        int         gap;
        pulses.delete();
        for (int i = 0; i < 16; i++) begin
            rs = 1'b0;
            if ($urandom_range(0, 1) == 1) rs = 1'b1;
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 2));
            lcd_on = ($urandom_range(0, 1) == 1);
            send_byte(rs, d, acc);
            if (i > 0) begin
                n_checks++;
                if (acc - acc_q[i-1] !== byte_period(rs_q[i-1], d_q[i-1])) begin
                    n_fail++;
                    $display("[TB] FAIL rand_spacing%0d: got %0d required %0d", i, acc - acc_q[i-1], byte_period(rs_q[i-1], d_q[i-1]));
                end
            end
            rs_q.push_back(rs);
            d_q.push_back(d);
            acc_q.push_back(acc);
            gap = $urandom_range(0, 4);
            if (gap > 0) begin
                req.req_vld  = 1'b0;
                req.req_rs   = ($urandom_range(0, 1) == 1);
                req.req_data = 8'($urandom_range(0, 255));
                tick(gap);
            end
        end
        req.req_vld = 1'b0;
        wait_idle();
        n_checks++;
        if (pulses.size() !== 16) begin
            n_fail++;
            $display("[TB] FAIL rand_pulse_count: got %0d required 16", pulses.size());
        end else begin
            for (int i = 0; i < 16; i++) check_pulse(i, rs_q[i], d_q[i], acc_q[i] + P_SETUP);
        end
        lcd_on = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   acc;
        int   r;
        int   done_cyc;
        logic seen;
        send_byte(1'b1, 8'h5A, acc);
        req.req_vld = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (io_lcd[8] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL mid_en_seen: EN never rose for byte 5A");
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        r = cyc;
        n_checks++;
        if (io_lcd[30:0] !== 31'h0 || init_done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_state: lcd=%h done=%b required 0 0", io_lcd[30:0], init_done);
        end
        n_checks++;
        if (req.req_rdy !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_flags: rdy=%b busy=%b required 0 1", req.req_rdy, busy);
        end
        @(negedge clk);
        #1;
        pulses.delete();
        acc_cyc_q.delete();
        done_cyc = -1000;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (init_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        n_checks++;
        if (done_cyc - r !== init_total()) begin
            n_fail++;
            $display("[TB] FAIL mid_replay_time: got %0d required %0d", done_cyc - r, init_total());
        end
        n_checks++;
        if (pulses.size() !== 4) begin
            n_fail++;
            $display("[TB] FAIL mid_replay_count: got %0d required 4", pulses.size());
        end else begin
            for (int k = 0; k < 4; k++) check_pulse(k, 1'b0, rom(k), r + init_en_start(k));
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_init_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
